// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor: 2-bit counter
// state encodings, counter reset value and instruction size for PC+4.
// Latency: n/a (constants only). Backpressure: n/a.
package branch_predictor_pkg;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT = 2'd0;  // strong not-taken
  localparam logic [1:0] WNT = 2'd1;  // weak not-taken
  localparam logic [1:0] WT  = 2'd2;  // weak taken
  localparam logic [1:0] ST  = 2'd3;  // strong taken

  // Counters come out of reset weakly not-taken
  localparam logic [1:0] CNT_RST = WNT;

  // Fall-through distance for sequential fetch
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve/redirect bundle between the predictor and the pipeline.
// Latency: n/a (wiring only). Backpressure: none, every signal is per-cycle.
// Ports: fetch_pc/pred_* (fetch lookup), res_* (execute training),
//        mispredict/redirect_pc (to PC logic), lookup_cnt/mispred_cnt (perf).
interface branch_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] fetch_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  logic            res_valid;
  logic            res_is_branch;
  logic [PC_W-1:0] res_pc;
  logic            res_taken;
  logic [PC_W-1:0] res_target;
  logic            res_pred_taken;
  logic [PC_W-1:0] res_pred_target;

  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     lookup_cnt;
  logic [31:0]     mispred_cnt;

  // Pipeline side: drives fetch PC and resolved outcomes
  modport master (
    output fetch_pc, res_valid, res_is_branch, res_pc, res_taken,
           res_target, res_pred_taken, res_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           lookup_cnt, mispred_cnt
  );

  // Predictor side
  modport slave (
    input  fetch_pc, res_valid, res_is_branch, res_pc, res_taken,
           res_target, res_pred_taken, res_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           lookup_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_bp_sat_counter2.sv
// 2-bit saturating counter next-state function for branch training.
// Latency: combinational. Backpressure: none.
// Ports: state (current counter), taken (resolved outcome), next (updated counter).
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = state;
    if (taken && (state != ST)) begin
      next = state + 2'd1;
    end else if (!taken && (state != SNT)) begin
      next = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with registered redirect.
// Latency: prediction combinational; mispredict/redirect_pc one cycle after resolve.
// Backpressure: none; every cycle is a lookup, every resolve slot is accepted.
// Ports: clk, rst_n (sync, active-low), bp (branch_predictor_if.slave).
// Optional build macro BP_PERF_CNT_EN adds saturating lookup/mispredict
// counters; without it lookup_cnt/mispred_cnt read 0.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0] PC_INC = PC_W'(INSTR_BYTES);

  // Table held in flops so reset can clear every entry
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  target_q[ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];

  // ---------------- fetch lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;

  assign f_idx = bp.fetch_pc[IDX_W+1:2];
  assign f_tag = bp.fetch_pc[PC_W-1:IDX_W+2];

  // Gate with rst_n so nothing is predicted while reset is held
  assign f_hit   = rst_n && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = f_hit && cnt_q[f_idx][1];

  assign bp.pred_hit    = f_hit;
  assign bp.pred_taken  = f_taken;
  assign bp.pred_target = f_taken ? target_q[f_idx] : (bp.fetch_pc + PC_INC);

  // ---------------- resolve / training ----------------
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             train;
  logic [1:0]       cnt_nxt;
  logic             mis_d;
  logic [PC_W-1:0]  redir_d;

  assign r_idx = bp.res_pc[IDX_W+1:2];
  assign r_tag = bp.res_pc[PC_W-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign train = bp.res_valid && bp.res_is_branch;

  bp_sat_counter2 u_sat (
    .state (cnt_q[r_idx]),
    .taken (bp.res_taken),
    .next  (cnt_nxt)
  );

  // A taken branch with the right direction but a stale target still redirects
  assign mis_d = train &&
                 ((bp.res_taken != bp.res_pred_taken) ||
                  (bp.res_taken && (bp.res_target != bp.res_pred_target)));

  assign redir_d = bp.res_taken ? bp.res_target : (bp.res_pc + PC_INC);

  // Table write. Lookups read the pre-edge contents, giving read-before-write
  // when fetch and resolve hit the same index in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RST;
      end
    end else if (train) begin
      if (r_hit) begin
        cnt_q[r_idx] <= cnt_nxt;
        if (bp.res_taken) begin
          target_q[r_idx] <= bp.res_target;
        end
      end else if (bp.res_taken) begin
        // Allocate on taken miss, evicting whatever aliased here
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= bp.res_target;
        cnt_q[r_idx]    <= WT;
      end
    end
  end

  // ---------------- registered redirect ----------------
  logic            mis_q;
  logic [PC_W-1:0] redir_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q   <= 1'b0;
      redir_q <= '0;
    end else begin
      mis_q <= mis_d;
      if (mis_d) begin
        redir_q <= redir_d;
      end
    end
  end

  assign bp.mispredict  = mis_q;
  assign bp.redirect_pc = redir_q;

  // ---------------- performance counters ----------------
`ifdef BP_PERF_CNT_EN
  logic [31:0] lookup_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lookup_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (lookup_q != '1) begin
        lookup_q <= lookup_q + 32'd1;
      end
      if (mis_d && (mispred_q != '1)) begin
        mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign bp.lookup_cnt  = lookup_q;
  assign bp.mispred_cnt = mispred_q;
`else
  assign bp.lookup_cnt  = 32'd0;
  assign bp.mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that pairs with the execute-stage branch controller. At fetch it predicts direction and target for the current PC from a direct-mapped table of 2-bit saturating counters and stored targets. At execute it takes the resolved outcome, trains the table, and pulses a registered mispredict/redirect to the PC logic.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, ≥2
- PC_W, 32, PC and target width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_pc  in  PC_W  PC being fetched this cycle
- pred_hit  out  1  table entry is valid and its tag matches
- pred_taken  out  1  predicted taken: pred_hit & counter[1]
- pred_target  out  PC_W  stored target when pred_taken, else fetch_pc+4
- res_valid  in  1  resolve slot holds a valid instruction
- res_is_branch  in  1  instruction is a conditional branch (BEQ/BNE/BLT/BGE)
- res_pc  in  PC_W  PC of the resolving instruction
- res_taken  in  1  actual outcome from the branch controller
- res_target  in  PC_W  computed branch target
- res_pred_taken  in  1  pred_taken carried down the pipeline
- res_pred_target  in  PC_W  pred_target carried down the pipeline
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  PC_W  registered correct next PC, valid when mispredict=1
- lookup_cnt  out  32  fetch lookups since reset
- mispred_cnt  out  32  mispredicts since reset

## Operation
- Index is PC[IDX_W+1:2], with IDX_W=log2(ENTRIES). Tag is PC[PC_W-1:IDX_W+2].
- Each entry holds valid, tag, target, and a 2-bit counter (0=strong NT, 1=weak NT, 2=weak T, 3=strong T).
- Lookup is combinational from fetch_pc. There is no fetch-valid input, so every cycle counts as a lookup.
- A training event is res_valid & res_is_branch. It is ignored otherwise.
- Training on a hit:
  - Taken: counter increments, saturating at 3, and target is overwritten with res_target.
  - Not taken: counter decrements, saturating at 0, and target is kept.
- Training on a miss:
  - Taken: allocate the entry with valid=1, the new tag, target=res_target, counter=2. This evicts any previous occupant.
  - Not taken: no write.
- Mispredict condition (training event only): res_taken≠res_pred_taken, or res_taken & (res_target≠res_pred_target).
- redirect_pc is res_target if res_taken, else res_pc+4. The +4 wraps modulo 2^PC_W.
- Non-branch instructions never raise mispredict, even if res_pred_taken=1. The decoder must not mark non-branches as predicted-taken.

## Timing
- Prediction has zero latency (combinational). Training writes at the clock edge.
- Same-cycle lookup and training of the same index: the prediction uses pre-write contents (read-before-write). The new state is visible from the next cycle.
- mispredict and redirect_pc are registered and appear one cycle after the resolving cycle. mispredict is high for exactly one cycle per mispredicting event. Back-to-back events give back-to-back pulses.
- Reset (rst_n=0 at a rising edge):
  - All valid bits cleared, all counters set to 1, targets and tags set to 0.
  - mispredict=0, redirect_pc=0, both counters 0.
  - During reset: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.
  - A training input coincident with reset is discarded.
- Reset asserted mid-operation discards any pending redirect. No pulse follows the reset release.

## Configuration
- BP_PERF_CNT_EN defined:
  - lookup_cnt increments every non-reset cycle.
  - mispred_cnt increments in the same cycle mispredict is registered high.
  - Both saturate at 2^32-1.
- BP_PERF_CNT_EN undefined: counter registers are not built, and lookup_cnt and mispred_cnt are tied to 0. Ports stay present.

## Structure
- Shared package: the counter-state constants (SNT=0, WNT=1, WT=2, ST=3), the counter reset value, and the instruction-width constant used for +4.
- One sub-module, bp_sat_counter2: a combinational 2-bit saturating next-state function, (state, taken) -> next. It is instantiated on the training path.
- The table is held in flops (valid/tag/target/counter arrays), not in an inferred RAM, so that reset can clear it.

## Test plan
- Reset, then fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; mispredict stays 0.
- Resolve 0x100, taken, target 0x40, pred NT -> next cycle mispredict=1, redirect_pc=0x40. A later fetch of 0x100 gives pred_hit=1, pred_taken=1, pred_target=0x40 (counter=2).
- Train 0x100 taken three more times (counter saturates at 3), then twice not-taken -> counter=1, pred_taken=0. The second not-taken with res_pred_taken=1 gives redirect_pc=0x104.
- Aliasing with ENTRIES=16: allocate 0x100, then train 0x140 taken to 0x80 (same index, different tag) -> fetch 0x100 misses, fetch 0x140 predicts 0x80.
- Same-cycle fetch and train of 0x200 (miss, taken) -> that cycle pred_hit=0; next cycle pred_hit=1.
- With BP_PERF_CNT_EN: 10 cycles after reset with 2 mispredicts -> lookup_cnt=10, mispred_cnt=2. Assert rst_n=0 with res_valid pending -> no mispredict pulse, counters read 0.
